// File: rtl/exmem_pkg.sv
// Shared types for the EX->MEM boundary register: payload layout, skid
// states and the stall counter width.
package exmem_pkg;

    localparam int PKG_XLEN    = 32;
    localparam int PKG_RA_W    = 5;
    localparam int PKG_SB_W    = 0;
    // Sideband storage is at least one bit wide so the field always exists.
    localparam int PKG_SB_WS   = (PKG_SB_W > 0) ? PKG_SB_W : 1;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [PKG_XLEN-1:0]  pc;
        logic [PKG_XLEN-1:0]  instr;
        logic [PKG_RA_W-1:0]  rd;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic [PKG_XLEN-1:0]  result;
        logic [PKG_XLEN-1:0]  sdata;
        logic [PKG_SB_WS-1:0] sb;
    } exmem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_st_e;

endpackage

// File: rtl/exmem_sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-low reset.
// Sticks at all-ones; only reset returns it to zero.
module exmem_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX->MEM pipeline boundary register with valid/ready handshake, flush and
// a stall-cycle counter.
// EXMEM_SKID_EN: when defined, a second (skid) entry lets ex_ready be driven
// from registered state only; when undefined, a single entry with a
// combinational ready pass-through.
module exmem_pipe_reg
    import exmem_pkg::*;
#(
    parameter int XLEN = PKG_XLEN,
    parameter int RA_W = PKG_RA_W,
    parameter int SB_W = PKG_SB_W,
    localparam int SBW = (SB_W > 0) ? SB_W : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [XLEN-1:0]        ex_instr,
    input  logic [XLEN-1:0]        ex_result,
    input  logic [XLEN-1:0]        ex_sdata,
    input  logic [RA_W-1:0]        ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem_write,
    input  logic                   ex_reg_write,
    input  logic [SBW-1:0]         ex_sb,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [XLEN-1:0]        mem_pc,
    output logic [XLEN-1:0]        mem_instr,
    output logic [XLEN-1:0]        mem_result,
    output logic [XLEN-1:0]        mem_sdata,
    output logic [RA_W-1:0]        mem_rd,
    output logic [SBW-1:0]         mem_sb,
    output logic                   mem_mem_read,
    output logic                   mem_mem_write,
    output logic                   mem_reg_write,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    skid_st_e       state_q, state_d;
    exmem_payload_t main_q, pkt_in;
    logic           in_fire, out_fire, ld_main_in;

    // Pack the incoming entry; an absent sideband is stored as zero.
    always_comb begin
        pkt_in           = '0;
        pkt_in.pc        = ex_pc;
        pkt_in.instr     = ex_instr;
        pkt_in.rd        = ex_rd;
        pkt_in.mem_read  = ex_mem_read;
        pkt_in.mem_write = ex_mem_write;
        pkt_in.reg_write = ex_reg_write;
        pkt_in.result    = ex_result;
        pkt_in.sdata     = ex_sdata;
        pkt_in.sb        = (SB_W > 0) ? ex_sb : '0;
    end

    assign mem_valid = (state_q != EMPTY);
    assign in_fire   = ex_valid & ex_ready & ~flush;
    assign out_fire  = mem_valid & mem_ready;

`ifdef EXMEM_SKID_EN
    exmem_payload_t skid_q;
    logic           ld_skid_in, ld_main_skid;

    // Ready comes from registered state only, so mem_ready never reaches it.
    assign ex_ready = (state_q != TWO);

    // Next state and register load selects; flush wins over both handshakes.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_skid_in   = 1'b0;
        ld_main_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d    = TWO;
                        ld_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Main entry: new input, or promotion of the skid entry on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            main_q <= '0;
        else if (ld_main_in)
            main_q <= pkt_in;
        else if (ld_main_skid)
            main_q <= skid_q;
    end

    // Skid entry captures the input that arrived while the head stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            skid_q <= '0;
        else if (ld_skid_in)
            skid_q <= pkt_in;
    end
`else
    // Single entry: accept when empty or when the head leaves this cycle.
    assign ex_ready = ~mem_valid | mem_ready;

    // Next state and load select; flush wins over both handshakes.
    always_comb begin
        state_d    = state_q;
        ld_main_in = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (in_fire) begin
            state_d    = ONE;
            ld_main_in = 1'b1;
        end else if (out_fire) begin
            state_d = EMPTY;
        end
    end

    // Main entry loads on every accepted input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            main_q <= '0;
        else if (ld_main_in)
            main_q <= pkt_in;
    end
`endif

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    assign mem_pc        = main_q.pc;
    assign mem_instr     = main_q.instr;
    assign mem_result    = main_q.result;
    assign mem_sdata     = main_q.sdata;
    assign mem_rd        = main_q.rd;
    assign mem_sb        = main_q.sb;
    // Stale payload may remain after a flush; controls must not leak out.
    assign mem_mem_read  = main_q.mem_read  & mem_valid;
    assign mem_mem_write = main_q.mem_write & mem_valid;
    assign mem_reg_write = main_q.reg_write & mem_valid;

    exmem_sat_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mem_valid & ~mem_ready),
        .cnt     (stall_cnt)
    );

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg: the reference is an ordered queue of
// accepted entries with a fixed capacity (2 with EXMEM_SKID_EN, else 1).
module tb_exmem_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_pc = '0, ex_instr = '0, ex_result = '0, ex_sdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
    logic [0:0]  ex_sb = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_pc, mem_instr, mem_result, mem_sdata;
    logic [4:0]  mem_rd;
    logic [0:0]  mem_sb;
    logic        mem_mem_read, mem_mem_write, mem_reg_write;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    exmem_pipe_reg dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_result(ex_result), .ex_sdata(ex_sdata),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_sb(ex_sb),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_result(mem_result), .mem_sdata(mem_sdata),
        .mem_rd(mem_rd), .mem_sb(mem_sb), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] pc, instr, result, sdata;
        logic [4:0]  rd;
        logic        mr, mw, rw;
    } ent_t;

    ent_t        q[$];
    logic [31:0] out_log[$];
    int          mcnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

`ifdef EXMEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: mid-cycle, compare the DUT against the queue model, then
    // advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            logic exp_rdy;
            ent_t e;
            if (CAP == 2) exp_rdy = (q.size() < 2);
            else          exp_rdy = (q.size() == 0) || mem_ready;
            chk("mem_valid", mem_valid, q.size() != 0);
            chk("ex_ready", ex_ready, exp_rdy);
            chk("stall_cnt", stall_cnt, mcnt);
            chk("mem_sb", mem_sb, 0);
            if (q.size() != 0) begin
                chk("mem_pc", mem_pc, q[0].pc);
                chk("mem_instr", mem_instr, q[0].instr);
                chk("mem_result", mem_result, q[0].result);
                chk("mem_sdata", mem_sdata, q[0].sdata);
                chk("mem_rd", mem_rd, q[0].rd);
                chk("mem_ctrl", {mem_mem_read, mem_mem_write, mem_reg_write},
                    {q[0].mr, q[0].mw, q[0].rw});
            end else begin
                chk("mem_ctrl_idle", {mem_mem_read, mem_mem_write, mem_reg_write}, 0);
            end
            if (q.size() != 0 && !mem_ready && mcnt < 16'hFFFF) mcnt++;
            if (q.size() != 0 && mem_ready) begin
                out_log.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (flush) q.delete();
            if (ex_valid && exp_rdy && !flush) begin
                e.pc = ex_pc; e.instr = ex_instr; e.result = ex_result; e.sdata = ex_sdata;
                e.rd = ex_rd; e.mr = ex_mem_read; e.mw = ex_mem_write; e.rw = ex_reg_write;
                q.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one entry and hold it until the stage takes it (bounded).
    task automatic send_hold(input logic [31:0] pc, input logic mr, input logic mw,
                             input logic rw, input logic [31:0] sd);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        ex_valid = 1'b1; ex_pc = pc; ex_instr = $urandom; ex_result = $urandom;
        ex_sdata = sd; ex_rd = 5'($urandom); ex_mem_read = mr; ex_mem_write = mw;
        ex_reg_write = rw;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ex_ready && !flush;
            @(posedge clk);
            #1;
            n++;
        end
        ex_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_mem_pc", mem_pc, 0);
        chk("rst_stall", stall_cnt, 0);
        #9 reset_n = 1'b1;
        cyc();

        // Back-to-back stream
        mem_ready = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h0; cyc();
        chk("stream0", {mem_valid, mem_pc}, {1'b1, 32'h0});
        ex_pc = 32'h4; cyc();
        chk("stream4", mem_pc, 32'h4);
        ex_pc = 32'h8; cyc();
        chk("stream8", mem_pc, 32'h8);
        chk("stream_ready", ex_ready, 1);
        chk("stream_stall", stall_cnt, 0);
        ex_valid = 1'b0;
        cyc();

        // Downstream stall absorb and in-order release
        send_hold(32'h10, 0, 0, 1, 32'h1);
        out_log.delete();
        mem_ready = 1'b0;
        fork
            begin
                repeat (3) cyc();
                mem_ready = 1'b1;
            end
            begin
                send_hold(32'h14, 1, 0, 1, 32'h2);
`ifdef EXMEM_SKID_EN
                chk("skid_ready_low", ex_ready, 0);
`endif
                send_hold(32'h18, 0, 1, 0, 32'h3);
            end
        join
        repeat (3) cyc();
        chk("stall_order_n", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("stall_order0", out_log[0], 32'h10);
            chk("stall_order1", out_log[1], 32'h14);
            chk("stall_order2", out_log[2], 32'h18);
        end

        // Flush a full stage while an input is offered
        mem_ready = 1'b0;
        send_hold(32'h30, 1, 0, 1, 32'h4);
`ifdef EXMEM_SKID_EN
        send_hold(32'h34, 1, 1, 1, 32'h5);
`endif
        out_log.delete();
        ex_valid = 1'b1; ex_pc = 32'h20; ex_mem_write = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0; ex_valid = 1'b0;
        chk("flush_valid", mem_valid, 0);
        chk("flush_ctrl", {mem_mem_read, mem_mem_write, mem_reg_write}, 0);
        chk("flush_ready", ex_ready, 1);
        mem_ready = 1'b1;
        repeat (3) cyc();
        chk("flush_no_out", out_log.size(), 0);

        // Control masking once the entry has left
        send_hold(32'h40, 0, 1, 0, 32'hDEADBEEF);
        chk("mask_live", {mem_valid, mem_mem_write, mem_sdata}, {1'b1, 1'b1, 32'hDEADBEEF});
        repeat (2) cyc();
        chk("mask_idle", {mem_valid, mem_mem_write}, 0);

        // Randomized traffic against the queue model
        repeat (400) begin
            ex_valid = 1'($urandom); ex_pc = $urandom; ex_instr = $urandom;
            ex_result = $urandom; ex_sdata = $urandom; ex_rd = 5'($urandom);
            ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
            ex_reg_write = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        ex_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        repeat (3) cyc();

        // Stall counter saturation
        mem_ready = 1'b0;
        send_hold(32'h50, 1, 0, 1, 32'h6);
        repeat (70000) cyc();
        chk("sat_cnt", stall_cnt, 16'hFFFF);
`ifdef EXMEM_SKID_EN
        send_hold(32'h54, 0, 1, 1, 32'h7);
`endif

        // Asynchronous reset between edges while full
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", mem_valid, 0);
        chk("arst_ready", ex_ready, 1);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_payload", {mem_pc, mem_sdata, mem_rd}, 0);
        chk("arst_ctrl", {mem_mem_read, mem_mem_write, mem_reg_write}, 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        mem_ready = 1'b1;
        cyc();
        chk("post_rst_stall", stall_cnt, 0);
        send_hold(32'h60, 1, 0, 0, 32'h8);
        chk("post_rst_first", {mem_valid, mem_pc}, {1'b1, 32'h60});
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
